// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_FORCE = 1'b1
  } arb_state_e;

  localparam int unsigned WAIT_CNT_WIDTH = 8;
  localparam int unsigned STAT_CNT_WIDTH = 16;

  // Saturating increment for the statistics counters
  function automatic logic [STAT_CNT_WIDTH-1:0] sat_inc(input logic [STAT_CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Debug starvation counter: counts cycles a debug request waits unacknowledged
// and requests a forced slot on the edge where the count reaches DBG_MAX_WAIT.
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic dbg_req_i,
  input  logic dbg_ack_i,
  output logic force_req_o
);

  localparam logic [WAIT_CNT_WIDTH-1:0] MAX_WAIT = WAIT_CNT_WIDTH'(DBG_MAX_WAIT);

  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  // Next wait count (saturating) and the force request on the final increment
  always_comb begin
    wait_cnt_d  = '0;
    force_req_o = 1'b0;
    if (dbg_req_i && !dbg_ack_i) begin
      if (wait_cnt_q != MAX_WAIT) begin
        wait_cnt_d  = wait_cnt_q + 1'b1;
        force_req_o = (wait_cnt_q == MAX_WAIT - 1'b1);
      end else begin
        wait_cnt_d  = wait_cnt_q;
      end
    end
  end

  // Wait counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the EX load/store path and the debug/loader port.
// EX has priority; a starving debug request gets one forced slot (EX stalled).
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DMEM_ADDR_WIDTH = 12,
  parameter int unsigned DMEM_WORD_WIDTH = 16,
  parameter int unsigned DBG_MAX_WAIT    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_ex_load,
  input  logic                       in_ex_store,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_ex_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_ex_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_ex_wr_word,
  output logic                       out_stall_ex,
  input  logic                       in_dbg_req,
  input  logic                       in_dbg_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dbg_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dbg_wdata,
  output logic                       out_dbg_ack,
  output logic                       out_dbg_rvalid,
  output logic [DMEM_WORD_WIDTH-1:0] out_dbg_rdata,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_addr,
  output logic                       out_dmem_re,
  output logic                       out_dmem_we,
  output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wdata,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rd_word,
  output logic [15:0]                out_stat_force_cnt,
  output logic [15:0]                out_stat_dbg_cnt
);

  arb_state_e state_q, state_d;
  logic       force_req;
  logic       dbg_ack;
  logic       rd_pend_q;

  dmem_arb_starve_cnt #(
    .DBG_MAX_WAIT (DBG_MAX_WAIT)
  ) u_starve_cnt (
    .clock       (clock),
    .reset       (reset),
    .dbg_req_i   (in_dbg_req),
    .dbg_ack_i   (dbg_ack),
    .force_req_o (force_req)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Next state: forced slot lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (force_req) state_d = ARB_FORCE;
      ARB_FORCE: state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Stall is a pure function of the registered state
  assign out_stall_ex = (state_q == ARB_FORCE);

  // Memory port mux and debug ack; everything held at 0 while reset is high
  always_comb begin
    out_dmem_addr  = '0;
    out_dmem_re    = 1'b0;
    out_dmem_we    = 1'b0;
    out_dmem_wdata = '0;
    dbg_ack        = 1'b0;
    if (!reset) begin
      if (state_q == ARB_IDLE && in_ex_store) begin
        // store wins over a simultaneous (illegal) load
        out_dmem_addr  = in_ex_wr_addr;
        out_dmem_we    = 1'b1;
        out_dmem_wdata = in_ex_wr_word;
      end else if (state_q == ARB_IDLE && in_ex_load) begin
        out_dmem_addr  = in_ex_rd_addr;
        out_dmem_re    = 1'b1;
      end else if (in_dbg_req) begin
        out_dmem_addr  = in_dbg_addr;
        out_dmem_re    = ~in_dbg_we;
        out_dmem_we    = in_dbg_we;
        out_dmem_wdata = in_dbg_we ? in_dbg_wdata : '0;
        dbg_ack        = 1'b1;
      end
    end
  end

  assign out_dbg_ack = dbg_ack;

  // Debug read pending: memory data returns one cycle after the read enable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_pend_q <= 1'b0;
    else       rd_pend_q <= dbg_ack & ~in_dbg_we;
  end

  assign out_dbg_rvalid = rd_pend_q;
  assign out_dbg_rdata  = rd_pend_q ? in_dmem_rd_word : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_CNT_WIDTH-1:0] force_cnt_q, dbg_cnt_q;

  // Saturating counts of forced cycles and debug grants
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      force_cnt_q <= '0;
      dbg_cnt_q   <= '0;
    end else begin
      if (state_q == ARB_FORCE) force_cnt_q <= sat_inc(force_cnt_q);
      if (dbg_ack)              dbg_cnt_q   <= sat_inc(dbg_cnt_q);
    end
  end

  assign out_stat_force_cnt = force_cnt_q;
  assign out_stat_dbg_cnt   = dbg_cnt_q;
`else
  assign out_stat_force_cnt = '0;
  assign out_stat_dbg_cnt   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: reference model plus scoreboard queue.
module tb_dmem_arbiter;

  localparam int AW   = 12;
  localparam int WW   = 16;
  localparam int MAXW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ex_load = 0, ex_store = 0;
  logic [AW-1:0] ex_rd_addr = '0, ex_wr_addr = '0;
  logic [WW-1:0] ex_wr_word = '0;
  logic          stall_ex;
  logic          dbg_req = 0, dbg_we = 0;
  logic [AW-1:0] dbg_addr = '0;
  logic [WW-1:0] dbg_wdata = '0;
  logic          dbg_ack, dbg_rvalid;
  logic [WW-1:0] dbg_rdata;
  logic [AW-1:0] dmem_addr;
  logic          dmem_re, dmem_we;
  logic [WW-1:0] dmem_wdata;
  logic [WW-1:0] dmem_rd_word = '0;
  logic [15:0]   stat_force, stat_dbg;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .DMEM_ADDR_WIDTH (AW),
    .DMEM_WORD_WIDTH (WW),
    .DBG_MAX_WAIT    (MAXW)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .in_ex_load         (ex_load),
    .in_ex_store        (ex_store),
    .in_ex_rd_addr      (ex_rd_addr),
    .in_ex_wr_addr      (ex_wr_addr),
    .in_ex_wr_word      (ex_wr_word),
    .out_stall_ex       (stall_ex),
    .in_dbg_req         (dbg_req),
    .in_dbg_we          (dbg_we),
    .in_dbg_addr        (dbg_addr),
    .in_dbg_wdata       (dbg_wdata),
    .out_dbg_ack        (dbg_ack),
    .out_dbg_rvalid     (dbg_rvalid),
    .out_dbg_rdata      (dbg_rdata),
    .out_dmem_addr      (dmem_addr),
    .out_dmem_re        (dmem_re),
    .out_dmem_we        (dmem_we),
    .out_dmem_wdata     (dmem_wdata),
    .in_dmem_rd_word    (dmem_rd_word),
    .out_stat_force_cnt (stat_force),
    .out_stat_dbg_cnt   (stat_dbg)
  );

  // Behavioural single-port memory driven by the DUT
  logic [WW-1:0] bmem [0:4095];
  always @(posedge clock) begin
    if (dmem_re) dmem_rd_word <= bmem[dmem_addr];
    if (dmem_we) bmem[dmem_addr] <= dmem_wdata;
  end

  typedef struct {
    logic          stall, ack, rvalid, re, we;
    logic [WW-1:0] rdata, wdata;
    logic [AW-1:0] addr;
    logic [15:0]   fcnt, dcnt;
  } exp_t;

  exp_t exp_q[$];
  int unsigned tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model state (rules expressed directly, not as an FSM)
  int            waited = 0;        // consecutive unacked cycles of the current debug request
  bit            pend = 0;
  logic [WW-1:0] pend_data = '0;
  int            fcnt = 0, dcnt = 0;
  logic [WW-1:0] ref_mem [0:4095];

  task automatic step(input bit rst, input bit ld, input bit st,
                      input logic [AW-1:0] rda, input logic [AW-1:0] wra, input logic [WW-1:0] wrw,
                      input bit req, input bit we, input logic [AW-1:0] da, input logic [WW-1:0] dw,
                      output bit ack);
    exp_t e;
    bit   force_now;
    reset = rst; ex_load = ld; ex_store = st; ex_rd_addr = rda; ex_wr_addr = wra;
    ex_wr_word = wrw; dbg_req = req; dbg_we = we; dbg_addr = da; dbg_wdata = dw;
    e = '{default: '0};
    ack = 0;
    if (rst) begin
      waited = 0; pend = 0; fcnt = 0; dcnt = 0;
    end else begin
      force_now = (waited == MAXW);
      ack = req && (force_now || !(ld || st));
      e.stall  = force_now;
      e.ack    = ack;
      e.rvalid = pend;
      e.rdata  = pend ? pend_data : '0;
`ifdef DMEM_ARB_STATS_EN
      e.fcnt = 16'(fcnt);
      e.dcnt = 16'(dcnt);
`endif
      if (!force_now && st) begin
        e.addr = wra; e.we = 1; e.wdata = wrw;
        ref_mem[wra] = wrw;
      end else if (!force_now && ld) begin
        e.addr = rda; e.re = 1;
      end else if (ack) begin
        e.addr = da; e.we = we; e.re = !we; e.wdata = we ? dw : '0;
      end
      pend = ack && !we;
      if (pend) pend_data = ref_mem[da];
      if (ack && we) ref_mem[da] = dw;
      waited = (req && !ack) ? ((waited + 1 > MAXW) ? MAXW : waited + 1) : 0;
      if (force_now && fcnt < 16'hFFFF) fcnt++;
      if (ack && dcnt < 16'hFFFF) dcnt++;
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: mid-cycle sample against the queued expectation
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("stall_ex", 32'(stall_ex), 32'(e.stall));
      chk("dbg_ack", 32'(dbg_ack), 32'(e.ack));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e.rvalid));
      chk("dbg_rdata", 32'(dbg_rdata), 32'(e.rdata));
      chk("dmem_addr", 32'(dmem_addr), 32'(e.addr));
      chk("dmem_re", 32'(dmem_re), 32'(e.re));
      chk("dmem_we", 32'(dmem_we), 32'(e.we));
      chk("dmem_wdata", 32'(dmem_wdata), 32'(e.wdata));
      chk("stat_force_cnt", 32'(stat_force), 32'(e.fcnt));
      chk("stat_dbg_cnt", 32'(stat_dbg), 32'(e.dcnt));
    end
  end

  // EX stores every cycle while debug reads; returns the cycle index of the ack
  task automatic run_starve(output int ack_cycle);
    bit ack;
    ack_cycle = -1;
    for (int i = 0; i <= MAXW + 2; i++) begin
      step(0, 0, 1, 12'h0, 12'(12'h100 + i), 16'(16'hA000 + i), 1, 0, 12'h005, 16'h0, ack);
      if (ack) begin
        ack_cycle = i;
        break;
      end
    end
    // replayed EX store, debug idle
    step(0, 0, 1, 12'h0, 12'h1FF, 16'hCAFE, 0, 0, 12'h0, 16'h0, ack);
  endtask

  initial begin
    bit   ack;
    int   ac;
    bit   dact, dwe, drop, busy, rst;
    logic [AW-1:0] dad;
    logic [WW-1:0] dwd;
    int   kind;

    for (int i = 0; i < 4096; i++) begin
      bmem[i]    = 16'(i * 7 + 3);
      ref_mem[i] = 16'(i * 7 + 3);
    end
    bmem[12'h010]    = 16'hBEEF;
    ref_mem[12'h010] = 16'hBEEF;

    @(posedge clock); #1;
    // reset state with EX active: outputs must be 0
    step(1, 1, 1, 12'h011, 12'h022, 16'h5555, 1, 1, 12'h033, 16'h6666, ack);
    step(0, 0, 0, 12'h0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, ack);

    // 1: idle pipeline debug read of 0x010
    step(0, 0, 0, 12'h0, 12'h0, 16'h0, 1, 0, 12'h010, 16'h0, ack);
    chk("idle_dbg_same_cycle_ack", 32'(ack), 32'd1);
    step(0, 0, 0, 12'h0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, ack);

    // 2 and 6: three starvation runs after a fresh reset
    step(1, 0, 0, 12'h0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, ack);
    for (int r = 0; r < 3; r++) begin
      run_starve(ac);
      chk("starve_ack_cycle", 32'(ac), 32'(MAXW));
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stats_force_after3", 32'(stat_force), 32'd3);
    chk("stats_dbg_after3", 32'(stat_dbg), 32'd3);
`else
    chk("stats_force_tied", 32'(stat_force), 32'd0);
    chk("stats_dbg_tied", 32'(stat_dbg), 32'd0);
`endif

    // 3: load and store together
    step(0, 1, 1, 12'h030, 12'h020, 16'h1234, 0, 0, 12'h0, 16'h0, ack);
    step(0, 1, 0, 12'h020, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, ack);

    // 4: reset in the cycle after a debug read ack
    step(0, 0, 0, 12'h0, 12'h0, 16'h0, 1, 0, 12'h010, 16'h0, ack);
    step(1, 1, 0, 12'h040, 12'h0, 16'h0, 1, 0, 12'h010, 16'h0, ack);
    step(1, 0, 1, 12'h0, 12'h041, 16'h7777, 0, 0, 12'h0, 16'h0, ack);
    step(0, 0, 0, 12'h0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, ack);

    // 5: request dropped after three waits, then a new request must wait in full
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 12'h0, 12'(12'h050 + i), 16'h1111, 1, 1, 12'h060, 16'h2222, ack);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 12'h0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, ack);
    run_starve(ac);
    chk("drop_then_full_wait", 32'(ac), 32'(MAXW));

    // randomized traffic with a debug agent that holds requests until ack
    dact = 0; dwe = 0; dad = '0; dwd = '0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!dact && $urandom_range(0, 2) == 0) begin
        dact = 1;
        dwe  = $urandom_range(0, 1) == 1;
        dad  = 12'($urandom_range(0, 15));
        dwd  = 16'($urandom);
      end
      drop = dact && ($urandom_range(0, 19) == 0);
      if (drop) dact = 0;
      busy = $urandom_range(0, 9) < 7;
      kind = $urandom_range(0, 19);
      step(rst, busy && (kind < 9 || kind == 19), busy && kind >= 9,
           12'($urandom_range(0, 15)), 12'($urandom_range(0, 15)), 16'($urandom),
           dact, dwe, dad, dwd, ack);
      if (ack || rst) dact = 0;
    end

    step(0, 0, 0, 12'h0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, ack);
    step(0, 0, 0, 12'h0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, ack);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
